// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one saturating up/down counter among N requesters.
// A granted requester gets a tenure of at most MAX_BURST operations, each answered with ack or nack.
module counter_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned W         = 8,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned LIMIT     = (2 ** W) - 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    input  logic [2*N-1:0]   op_i,
    output logic [N-1:0]     gnt_o,
    output logic [N-1:0]     ack_o,
    output logic [N-1:0]     nack_o,
    output logic [W-1:0]     count_o,
    output logic             busy_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned BW = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_last;
    logic [BW-1:0]   r_burst;
    logic [W-1:0]    r_count;
    logic [N-1:0]    r_gnt;
    logic [N-1:0]    r_ack;
    logic [N-1:0]    r_nack;
    logic            r_busy;

    logic            w_found;
    logic [IW-1:0]   w_sel;
    logic [IW-1:0]   w_idx;
    logic [1:0]      w_op;
    logic            w_apply;
    logic [W-1:0]    w_next;

    // First requesting index after the last owner, with wrap-around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            w_idx = IW'((32'(r_last) + i) % N);
            if (!w_found && req_i[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // Owner's operation decode against the saturation bounds.
    always_comb begin
        w_op    = op_i[{r_owner, 1'b0} +: 2];
        w_apply = 1'b0;
        w_next  = r_count;
        case (w_op)
            2'b01: begin
                w_apply = (r_count < W'(LIMIT));
                w_next  = r_count + W'(1);
            end
            2'b10: begin
                w_apply = (r_count != '0);
                w_next  = r_count - W'(1);
            end
            default: begin
                w_apply = 1'b0;
                w_next  = r_count;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_last  <= IW'(N - 1);
            r_burst <= '0;
            r_count <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_nack  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_ack  <= '0;
            r_nack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_OWN;
                        r_owner <= w_sel;
                        r_gnt   <= N'(1) << w_sel;
                        r_busy  <= 1'b1;
                        r_burst <= '0;
                    end
                end
                S_OWN: begin
                    if (!req_i[r_owner]) begin
                        r_state <= S_IDLE;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_last  <= r_owner;
                    end else begin
                        if (w_apply) begin
                            r_count        <= w_next;
                            r_ack[r_owner] <= 1'b1;
                        end else begin
                            r_nack[r_owner] <= 1'b1;
                        end
                        r_burst <= r_burst + BW'(1);
                        // Tenure ends after the op that fills the burst budget.
                        if (r_burst == BW'(MAX_BURST - 1)) begin
                            r_state <= S_IDLE;
                            r_gnt   <= '0;
                            r_busy  <= 1'b0;
                            r_last  <= r_owner;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt_o   = r_gnt;
    assign ack_o   = r_ack;
    assign nack_o  = r_nack;
    assign count_o = r_count;
    assign busy_o  = r_busy;
    assign full_o  = (r_count == W'(LIMIT));
    assign empty_o = (r_count == '0);

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: directed scenarios with literal expectations plus
// random traffic, all checked every cycle against a behavioural model.
module tb_counter_arbiter;

    localparam int unsigned N         = 4;
    localparam int unsigned W         = 5;
    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned LIMIT     = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [2*N-1:0]   op;
    logic [N-1:0]     gnt, ack, nack;
    logic [W-1:0]     count;
    logic             busy, full, empty;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_no = 0;

    // Model state: owner index or -1 when idle.
    int m_own, m_last, m_burst, m_count;
    logic [N-1:0] e_ack, e_nack;

    counter_arbiter #(.N(N), .W(W), .MAX_BURST(MAX_BURST), .LIMIT(LIMIT)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .op_i    (op),
        .gnt_o   (gnt),
        .ack_o   (ack),
        .nack_o  (nack),
        .count_o (count),
        .busy_o  (busy),
        .full_o  (full),
        .empty_o (empty)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc_no, act, exp);
        end
    endfunction

    function automatic void model_step(input logic r, input logic [N-1:0] rq, input logic [2*N-1:0] o);
        logic [1:0] c;
        e_ack  = '0;
        e_nack = '0;
        if (r) begin
            m_own = -1; m_last = N - 1; m_burst = 0; m_count = 0;
        end else if (m_own < 0) begin
            for (int k = 1; k <= N; k++) begin
                int cand;
                cand = (m_last + k) % N;
                if (m_own < 0 && rq[cand]) begin
                    m_own = cand;
                    m_burst = 0;
                end
            end
        end else if (!rq[m_own]) begin
            m_last = m_own;
            m_own = -1;
        end else begin
            c = o[2*m_own +: 2];
            if (c == 2'b01 && m_count < LIMIT) begin
                m_count++; e_ack[m_own] = 1'b1;
            end else if (c == 2'b10 && m_count > 0) begin
                m_count--; e_ack[m_own] = 1'b1;
            end else begin
                e_nack[m_own] = 1'b1;
            end
            m_burst++;
            if (m_burst == MAX_BURST) begin
                m_last = m_own;
                m_own = -1;
            end
        end
    endfunction

    // Apply inputs for one clock, advance the model, then compare all outputs.
    task automatic step(input logic r, input logic [N-1:0] rq, input logic [2*N-1:0] o);
        logic [N-1:0] e_gnt;
        rst = r; req = rq; op = o;
        @(posedge clk);
        cyc_no++;
        model_step(r, rq, o);
        #1;
        e_gnt = (m_own >= 0) ? (N'(1) << m_own) : '0;
        check("gnt",   32'(gnt),   32'(e_gnt));
        check("ack",   32'(ack),   32'(e_ack));
        check("nack",  32'(nack),  32'(e_nack));
        check("count", 32'(count), 32'(m_count));
        check("busy",  32'(busy),  32'(m_own >= 0));
        check("full",  32'(full),  32'(m_count == LIMIT));
        check("empty", 32'(empty), 32'(m_count == 0));
    endtask

    localparam logic [2*N-1:0] ALL_INC = 8'b01010101;

    logic [N-1:0]   rreq;
    logic [2*N-1:0] rop;
    logic           up_mode;

    initial begin
        m_own = -1; m_last = N - 1; m_burst = 0; m_count = 0;
        rst = 1'b1; req = '0; op = '0;

        // Single requester: grant, four acks, release, one idle gap, regrant.
        step(1'b1, 4'b0000, '0);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        step(1'b0, 4'b0001, ALL_INC);
        check("p1_gnt", 32'(gnt), 32'h1);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0001, ALL_INC);
        check("p1_count", 32'(count), 32'd4);
        check("p1_release", 32'(gnt), 32'h0);
        step(1'b0, 4'b0001, ALL_INC);
        check("p1_regrant", 32'(gnt), 32'h1);

        // All requesting: rotation 0,1,2,3,0 with an idle cycle between tenures.
        step(1'b1, '0, '0);
        for (int i = 1; i <= 27; i++) begin
            step(1'b0, 4'b1111, ALL_INC);
            if (i == 1)  check("rot_g0", 32'(gnt), 32'h1);
            if (i == 6)  check("rot_g1", 32'(gnt), 32'h2);
            if (i == 11) check("rot_g2", 32'(gnt), 32'h4);
            if (i == 16) check("rot_g3", 32'(gnt), 32'h8);
            if (i == 20) check("rot_count16", 32'(count), 32'd16);
            if (i == 21) check("rot_g0b", 32'(gnt), 32'h1);
            if (i == 25) check("sat_full", 32'(full), 32'h1);
            if (i == 27) check("sat_nack", 32'(nack), 32'h2);
        end
        check("sat_count", 32'(count), 32'd20);

        // Decrement at zero and op 11 are both rejected.
        step(1'b1, '0, '0);
        step(1'b0, 4'b0010, 8'b00001000);
        check("e_gnt", 32'(gnt), 32'h2);
        step(1'b0, 4'b0010, 8'b00001000);
        check("e_nack10", 32'(nack), 32'h2);
        check("e_empty", 32'(empty), 32'h1);
        step(1'b0, 4'b0010, 8'b00001100);
        check("e_nack11", 32'(nack), 32'h2);
        check("e_count", 32'(count), 32'h0);

        // Owner drops request after two acks.
        step(1'b1, '0, '0);
        step(1'b0, 4'b0011, ALL_INC);
        step(1'b0, 4'b0011, ALL_INC);
        step(1'b0, 4'b0011, ALL_INC);
        check("d_count", 32'(count), 32'd2);
        step(1'b0, 4'b0010, ALL_INC);
        check("d_gnt", 32'(gnt), 32'h0);
        check("d_pulses", 32'({ack, nack}), 32'h0);
        step(1'b0, 4'b0010, ALL_INC);
        check("d_next", 32'(gnt), 32'h2);

        // Reset mid-tenure discards the sampled op and restarts arbitration at 0.
        step(1'b1, '0, '0);
        for (int i = 0; i < 7; i++) step(1'b0, 4'b0001, ALL_INC);
        check("r_count5", 32'(count), 32'd5);
        step(1'b1, 4'b0001, ALL_INC);
        check("r_count", 32'(count), 32'h0);
        check("r_gnt", 32'(gnt), 32'h0);
        check("r_ack", 32'(ack), 32'h0);
        step(1'b0, 4'b1111, ALL_INC);
        check("r_first", 32'(gnt), 32'h1);

        // Random traffic with sticky requests and phases biased up or down.
        rreq = '0;
        up_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 80 == 0) up_mode = ~up_mode;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) rreq[b] = ~rreq[b];
                if ($urandom_range(0, 3) != 0) rop[2*b +: 2] = up_mode ? 2'b01 : 2'b10;
                else rop[2*b +: 2] = 2'($urandom_range(0, 3));
            end
            step($urandom_range(0, 199) == 0, rreq, rop);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_arbiter.md
Name: counter_arbiter

Overview:
- Shares one saturating up/down counter (same op encoding as the team's utility counter: 01 increment, 10 decrement, 00/11 hold) between N requesters.
- Round-robin arbitration grants one requester a bounded tenure (burst) of counter operations.
- Per-operation ack/nack tells each requester whether its operation was applied.
- Sits between software- or FSM-driven clients and a shared occupancy/credit counter.

Parameters:
- N, 4, number of requesters (2..16)
- W, 8, counter width
- MAX_BURST, 4, maximum operations per grant tenure (1..255)
- LIMIT, 2**W-1, upper saturation value of the count (must be <= 2**W-1)

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, synchronous, active-high
- req_i  input  N  per-requester request level; held high while the requester wants or holds the counter
- op_i  input  2*N  per-requester op; requester k uses op_i[2k+1:2k]
- gnt_o  output  N  one-hot registered grant; at most one bit set
- ack_o  output  N  one-cycle pulse: owner's op was applied
- nack_o  output  N  one-cycle pulse: owner's op was rejected (saturation or 00/11 op)
- count_o  output  W  current count
- busy_o  output  1  high while in OWN
- full_o  output  1  count_o == LIMIT
- empty_o  output  1  count_o == 0

Behaviour:
- Reset (rst_i sampled high at a rising edge; takes priority over every other event):
  - state IDLE; gnt_o, ack_o, nack_o = 0; count_o = 0; busy_o = 0; full_o = 0; empty_o = 1
  - last-owner pointer = N-1, so requester 0 wins the first arbitration
  - burst counter = 0
  - reset mid-tenure aborts the tenure; an op sampled at the same edge is discarded
- FSM states: IDLE, OWN.
- IDLE:
  - if any req_i bit is high, select the first set bit searching from (last+1) mod N upward with wrap
  - next cycle: gnt_o = onehot(sel), state OWN, burst = 0
  - no req: remain IDLE
- OWN, each edge with owner o:
  - req_i[o] low: release with no ack/nack; count unchanged
  - req_i[o] high, op 01:
    - count < LIMIT: count+1, ack_o[o]
    - otherwise: nack_o[o]
  - req_i[o] high, op 10:
    - count > 0: count-1, ack_o[o]
    - otherwise: nack_o[o]
  - req_i[o] high, op 00 or 11: nack_o[o]; count held
  - every ack or nack increments burst; burst reaching MAX_BURST releases after that op
- Release:
  - next cycle: state IDLE, gnt_o = 0, busy_o = 0, last = o
  - IDLE always lasts at least one cycle (arbitration gap); a tenure never extends past release even if req stays high
- Latency:
  - req rises at edge t (IDLE) -> gnt_o high after edge t+1
  - op sampled at the first edge with gnt_o high -> ack/nack pulse and updated count visible after that same edge (1-cycle op latency)
  - back-to-back ops every cycle while granted
- Arithmetic:
  - count never wraps; saturates at 0 and LIMIT
  - full_o/empty_o are combinational from count_o
- Other rules:
  - op_i and req_i of non-owners are ignored in OWN
  - ack_o/nack_o never both high, and only ever on the owner bit
  - a non-owner dropping req has no effect

Test Plan:
- Reset, then req_i=0001 with op 01 held -> gnt_o=0001 one cycle later; 4 acks; count_o 0->4; release; 1 idle cycle; regrant to requester 0 (only requester).
- req_i=1111 held, all ops 01, MAX_BURST=4 -> grants rotate 0,1,2,3,0 with one idle cycle between tenures; count_o=16 after four tenures.
- W=3, LIMIT=7, count=6, owner issues 01 three times -> ack, nack, nack; count_o stays 7; full_o=1.
- count=0, owner issues 10 -> nack_o pulse; count_o=0; empty_o=1. Owner issues op 11 -> nack; count unchanged.
- Owner drops req_i after 2 acks -> no further pulses; gnt_o clears next cycle; pointer advances; next requester granted after the idle cycle.
- rst_i asserted mid-tenure with op 01 at count=5 -> after that edge count_o=0, gnt_o=0, no ack; next arbitration grants requester 0 first.
